simple_st0_bias_ctrl: RTL and testbench
=======================================

SIMPLE_ST0_BIAS_CTRL -- requirements
Module: simple_st0_bias_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, bias word width.
- DEPTH, 4, bias memory entries.
- ADDR_W, 2, address width, equal to log2(DEPTH).
REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load word offered.
- load_data  input  WIDTH  load word.
- load_ready  output  1  load word accepted when load_valid=1.
- start  input  1  begin streaming bias words.
- bias_valid  output  1  bias word presented.
- bias_data  output  WIDTH  bias word.
- bias_ready  input  1  downstream accepts.
- busy  output  1  block is not IDLE.
- mem_addr  output  ADDR_W  memory address.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_data  output  WIDTH  memory write data.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_data  input  WIDTH  memory read data, valid exactly 1 cycle after mem_rd_en.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RD_REQ, RD_WAIT and OUT, plus a registered ADDR_W-bit pointer ptr.
REQ-004 load_ready SHALL be 1 when (IDLE and start=0) or LOAD, and 0 otherwise (combinational).
REQ-005 A load handshake (load_valid and load_ready) SHALL drive the following in the same cycle:
- mem_wr_en=1, mem_addr=ptr, mem_wr_data=load_data.
- ptr increments by 1.
REQ-006 A handshake in IDLE SHALL go to LOAD.
REQ-007 A handshake in LOAD with ptr=DEPTH-1 SHALL write the last entry, set ptr to 0, and go to IDLE; otherwise the FSM stays in LOAD.
REQ-008 In LOAD, start SHALL be ignored; there is no timeout.
REQ-009 In IDLE, start=1 SHALL set ptr to 0 and go to RD_REQ. start takes priority over a simultaneous load_valid, which is not accepted.
REQ-010 RD_REQ SHALL assert mem_rd_en=1 with mem_addr=ptr for one cycle, then go to RD_WAIT.
REQ-011 RD_WAIT SHALL capture mem_rd_data into the bias_data register, then go to OUT.
REQ-012 OUT SHALL hold bias_valid=1 and a stable bias_data until bias_ready=1.
REQ-013 On an OUT handshake:
- ptr=DEPTH-1: ptr goes to 0, and the FSM goes to IDLE (or as REQ-020).
- otherwise: ptr increments, and the FSM goes to RD_REQ.
REQ-014 Latency SHALL be 2 cycles from start sampled to bias_valid=1, and 3 cycles per word with bias_ready held at 1.
REQ-015 mem_wr_en and mem_rd_en SHALL never both be 1, and SHALL both be 0 outside REQ-005 and REQ-010.
REQ-016 mem_addr SHALL equal ptr in every cycle.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 ptr SHALL wrap modulo DEPTH; no out-of-range address is ever produced.

Reset
REQ-019 While reset=1, regardless of clock, the block SHALL hold:
- state=IDLE, ptr=0, bias_data=0.
- bias_valid=0, busy=0, mem_wr_en=0, mem_rd_en=0.
- load_ready=1 when start=0.
A mid-load or mid-stream operation is abandoned and is not resumed after reset deasserts.

Configuration
REQ-020 With macro SIMPLE_ST0_BIAS_CTRL_REPEAT_EN defined, the block SHALL add input port repeat (1 bit). If repeat=1 at the final OUT handshake (ptr=DEPTH-1), the FSM goes to RD_REQ with ptr=0 instead of IDLE. repeat=0, or deassertion mid-stream, ends the stream normally after the last word.
REQ-021 Without SIMPLE_ST0_BIAS_CTRL_REPEAT_EN, the repeat port SHALL be absent and the final handshake always returns to IDLE.

Verification
REQ-022 Load: load_valid=1 with data 0x11,0x22,0x33,0x44 on consecutive cycles:
- 4 writes at addr 0,1,2,3.
- busy=1 from cycle 2, FSM in IDLE after the fourth write.
REQ-023 Stream: after REQ-022, pulse start with bias_ready=1:
- bias_valid rises 2 cycles later.
- Words 0x11,0x22,0x33,0x44 are delivered 3 cycles apart.
- busy falls after the fourth handshake.
REQ-024 Backpressure: hold bias_ready=0 for 5 cycles on word 2:
- bias_data=0x33 stays stable and mem_rd_en=0 throughout.
- The stream completes in order after release.
REQ-025 Conflicts:
- start and load_valid asserted together in IDLE: load_ready=0, no write, the stream starts.
- start pulsed during LOAD: ignored.
REQ-026 Reset in RD_WAIT: assert reset asynchronously mid-cycle:
- Outputs go to their REQ-019 values immediately.
- A new start streams from addr 0.
REQ-027 With SIMPLE_ST0_BIAS_CTRL_REPEAT_EN and repeat=1: 8 words arrive (0x11..0x44 twice); dropping repeat during the second pass ends the stream after 0x44.

Source files
------------

// File: rtl/simple_st0_bias_ctrl_if.sv
// Load / bias-stream / memory bus bundle for simple_st0_bias_ctrl.
// slave is the controller side, master is the load source, sink and memory side.
interface simple_st0_bias_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 2
);
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_ready;
  logic              start;
  logic              bias_valid;
  logic [WIDTH-1:0]  bias_data;
  logic              bias_ready;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              mem_rd_en;
  logic [WIDTH-1:0]  mem_rd_data;

  modport slave (
    input  load_valid, load_data, start, bias_ready, mem_rd_data,
    output load_ready, bias_valid, bias_data, busy,
           mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
  );

  modport master (
    output load_valid, load_data, start, bias_ready, mem_rd_data,
    input  load_ready, bias_valid, bias_data, busy,
           mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
  );
endinterface

// File: rtl/simple_st0_bias_ctrl.sv
// Bias controller: loads DEPTH words into an external memory, then streams them out.
// Optional SIMPLE_ST0_BIAS_CTRL_REPEAT_EN adds repeat_on (the "repeat" input) to loop the stream.
module simple_st0_bias_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef SIMPLE_ST0_BIAS_CTRL_REPEAT_EN
  input  logic repeat_on,
`endif
  simple_st0_bias_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  bias_q;
  logic              valid_q;
  logic              busy_q;
  logic              rd_en_q;
  logic              again;
  logic              load_hs;

`ifdef SIMPLE_ST0_BIAS_CTRL_REPEAT_EN
  assign again = repeat_on;
`else
  assign again = 1'b0;
`endif

  assign bus.load_ready  = (state == IDLE && !bus.start) || state == LOAD;
  // Write strobe is gated by reset so an offered word is never written while reset holds.
  assign load_hs         = bus.load_valid && bus.load_ready && !reset;
  assign bus.mem_wr_en   = load_hs;
  assign bus.mem_wr_data = bus.load_data;
  assign bus.mem_addr    = ptr;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.bias_valid  = valid_q;
  assign bus.bias_data   = bias_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      bias_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ptr     <= '0;
            state   <= RD_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (load_hs) begin
            ptr    <= ptr + ADDR_W'(1);
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          if (load_hs) begin
            if (ptr == LAST) begin
              ptr    <= '0;
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        RD_REQ: begin
          rd_en_q <= 1'b0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          bias_q  <= bus.mem_rd_data;
          valid_q <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (bus.bias_ready) begin
            valid_q <= 1'b0;
            if (ptr == LAST) begin
              ptr <= '0;
              if (again) begin
                state   <= RD_REQ;
                rd_en_q <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              ptr     <= ptr + ADDR_W'(1);
              state   <= RD_REQ;
              rd_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_st0_bias_ctrl.sv
// Self-checking bench for simple_st0_bias_ctrl: load table, stream scoreboard, corner sequences.
module tb_simple_st0_bias_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef SIMPLE_ST0_BIAS_CTRL_REPEAT_EN
  logic repeat_on = 1'b0;
`endif

  always #5 clk = ~clk;

  simple_st0_bias_ctrl_if #(.WIDTH(32), .ADDR_W(2)) bus();

  simple_st0_bias_ctrl #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SIMPLE_ST0_BIAS_CTRL_REPEAT_EN
    .repeat_on (repeat_on),
`endif
    .bus   (bus.slave)
  );

  // Behavioural memory: one-cycle read latency.
  logic [31:0] mem [4];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every accepted bias word must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      check("rd_wr_exclusive", {31'b0, bus.mem_wr_en & bus.mem_rd_en}, 32'h0);
      if (bus.bias_valid && bus.bias_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.bias_data, 32'hDEAD_BEEF);
        else check("bias_word", bus.bias_data, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        lv;
    logic        st;
    logic [31:0] data;
    logic        e_ready;
    logic        e_wr;
    logic [1:0]  e_addr;
    logic        e_busy;
  } load_vec_t;

  load_vec_t lv_tab[6];

  task automatic push_words();
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.bias_valid) return;
    end
    check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        check({name, "_queue_left"}, exp_q.size(), 0);
        return;
      end
    end
    check({name, "_busy_timeout"}, 32'h1, 32'h0);
    exp_q.delete();
  endtask

  initial begin
    bus.load_valid = 1'b0; bus.load_data = '0; bus.start = 1'b0; bus.bias_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) mem[i] = 32'hA5A5_0000 + i;

    lv_tab[0] = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 2'd0, 1'b0};
    lv_tab[1] = '{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 2'd1, 1'b1};
    lv_tab[2] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 2'd2, 1'b1};
    lv_tab[3] = '{1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 2'd2, 1'b1};
    lv_tab[4] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 2'd3, 1'b1};
    lv_tab[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 2'd0, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.bias_valid, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_bias_data", bus.bias_data, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Load table, including a start pulse ignored while in LOAD
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.load_valid = lv_tab[i].lv;
      bus.start      = lv_tab[i].st;
      bus.load_data  = lv_tab[i].data;
      @(negedge clk);
      check($sformatf("load%0d_ready", i), bus.load_ready, lv_tab[i].e_ready);
      check($sformatf("load%0d_wr_en", i), bus.mem_wr_en, lv_tab[i].e_wr);
      check($sformatf("load%0d_addr", i), bus.mem_addr, lv_tab[i].e_addr);
      check($sformatf("load%0d_busy", i), bus.busy, lv_tab[i].e_busy);
      if (lv_tab[i].e_wr) check($sformatf("load%0d_wdata", i), bus.mem_wr_data, lv_tab[i].data);
    end
    bus.load_valid = 1'b0; bus.start = 1'b0;

    // Full-rate stream: valid 2 cycles after start is sampled, then every 3 cycles
    bus.bias_ready = 1'b1;
    push_words();
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("strm%0d_valid", c), bus.bias_valid, (c % 3 == 2) ? 1 : 0);
      check($sformatf("strm%0d_rd_en", c), bus.mem_rd_en, (c % 3 == 0) ? 1 : 0);
      check($sformatf("strm%0d_addr", c), bus.mem_addr, c / 3);
      check($sformatf("strm%0d_busy", c), bus.busy, 1);
    end
    @(negedge clk);
    check("strm_busy_end", bus.busy, 0);
    check("strm_queue_left", exp_q.size(), 0);

    // Backpressure on word 2
    bus.bias_ready = 1'b0;
    push_words();
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      wait_valid($sformatf("bp_word%0d", w));
      if (w == 2) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("bp_hold_valid", bus.bias_valid, 1);
          check("bp_hold_data", bus.bias_data, 32'h33);
          check("bp_hold_rd_en", bus.mem_rd_en, 0);
        end
      end
      @(posedge clk); #1 bus.bias_ready = 1'b1;
      @(posedge clk); #1 bus.bias_ready = 1'b0;
    end
    wait_idle("bp");

    // start and load_valid together in IDLE: no write, stream starts
    bus.bias_ready = 1'b1;
    push_words();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 32'h99;
    @(negedge clk);
    check("conf_load_ready", bus.load_ready, 0);
    check("conf_wr_en", bus.mem_wr_en, 0);
    @(posedge clk); #1 bus.start = 1'b0; bus.load_valid = 1'b0;
    @(negedge clk);
    check("conf_busy", bus.busy, 1);
    wait_idle("conf");

    // Asynchronous reset in RD_WAIT, then a fresh stream from address 0
    pulse_start();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_valid", bus.bias_valid, 0);
    check("ar_rd_en", bus.mem_rd_en, 0);
    check("ar_wr_en", bus.mem_wr_en, 0);
    check("ar_bias_data", bus.bias_data, 0);
    check("ar_addr", bus.mem_addr, 0);
    check("ar_load_ready", bus.load_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_stays_idle", bus.busy, 0);
    push_words();
    pulse_start();
    @(negedge clk);
    check("ar_restart_rd_en", bus.mem_rd_en, 1);
    check("ar_restart_addr", bus.mem_addr, 0);
    wait_idle("ar_restart");

`ifdef SIMPLE_ST0_BIAS_CTRL_REPEAT_EN
    // Repeat: two passes, repeat dropped during the second pass
    push_words(); push_words();
    repeat_on = 1'b1;
    pulse_start();
    for (int w = 0; w < 5; w++) begin
      wait_valid($sformatf("rep_word%0d", w));
      @(posedge clk); #1;
    end
    repeat_on = 1'b0;
    wait_idle("rep");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
